// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes and response-FSM state encoding shared by alu_arbiter and its tests.
// Revision: 1.0
`default_nettype none

package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_arb_rr.sv
// alu_arb_rr: round-robin picker, searches from (last_grant+1) mod NREQ, one-hot or zero grant.
// Revision: 1.0
`default_nettype none

module alu_arb_rr #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   last_grant,
  input  logic            enable,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    if (!enable) grant = '0;
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// alu_arbiter: NREQ requesters share one ALU through a round-robin arbiter and a 1-deep result register.
// Optional feature macro: ALU_ARBITER_PERF_EN (per-requester saturating grant counters). Revision: 1.0
`default_nettype none

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [3*NREQ-1:0]    req_op,
  input  logic [DW*NREQ-1:0]   req_src1,
  input  logic [DW*NREQ-1:0]   req_src2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [DW-1:0]        rsp_result,
`ifdef ALU_ARBITER_PERF_EN
  output logic [32*NREQ-1:0]   grant_cnt,
`endif
  output logic                 rsp_zero
);

  localparam int IW = $clog2(NREQ);

  state_t          state, state_nx;
  logic            accept_en;
  logic [NREQ-1:0] grant;
  logic            xfer;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   sel_idx;
  logic [2:0]      sel_op;
  logic [DW-1:0]   sel_a, sel_b, alu_res;
  logic            shift_big;

  // Reset gating keeps req_ready low for as long as rst_n is asserted.
  alu_arb_rr #(.NREQ(NREQ), .IW(IW)) u_rr (
    .valid      (req_valid),
    .last_grant (last_grant),
    .enable     (accept_en & rst_n),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign rsp_valid = (state == ST_FULL);

  always_comb begin
    sel_idx = '0;
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_idx = IW'(i);
        sel_op  = req_op[3*i +: 3];
        sel_a   = req_src1[DW*i +: DW];
        sel_b   = req_src2[DW*i +: DW];
      end
    end
  end

  assign shift_big = (64'(sel_b) >= 64'(DW));

  always_comb begin
    alu_res = '0;
    case (sel_op)
      ALU_AND: alu_res = sel_a & sel_b;
      ALU_OR:  alu_res = sel_a | sel_b;
      ALU_ADD: alu_res = sel_a + sel_b;
      ALU_SUB: alu_res = sel_a - sel_b;
      ALU_SLT: alu_res = {{(DW-1){1'b0}}, (sel_a < sel_b)};
      ALU_XOR: alu_res = sel_a ^ sel_b;
      ALU_SLL: alu_res = shift_big ? '0 : (sel_a << sel_b);
      ALU_SRL: alu_res = shift_big ? '0 : (sel_a >> sel_b);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_nx  = state;
    accept_en = (state == ST_EMPTY) || rsp_ready;
    if (xfer) begin
      state_nx = ST_FULL;
    end else if (state == ST_FULL && rsp_ready) begin
      state_nx = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_id     <= '0;
      rsp_zero   <= 1'b1;
      last_grant <= IW'(NREQ - 1);
    end else if (xfer) begin
      rsp_result <= alu_res;
      rsp_id     <= sel_idx;
      rsp_zero   <= (alu_res == '0);
      last_grant <= sel_idx;
    end
  end

`ifdef ALU_ARBITER_PERF_EN
  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          grant_cnt[32*g +: 32] <= '0;
        end else if (grant[g] && grant_cnt[32*g +: 32] != 32'hFFFF_FFFF) begin
          grant_cnt[32*g +: 32] <= grant_cnt[32*g +: 32] + 32'd1;
        end
      end
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model.
// Revision: 1.0
`default_nettype none

module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2:0]        op [NREQ];
  logic [DW-1:0]     s1 [NREQ];
  logic [DW-1:0]     s2 [NREQ];
  logic [3*NREQ-1:0]  req_op;
  logic [DW*NREQ-1:0] req_src1, req_src2;
  logic              rsp_valid, rsp_ready, rsp_zero;
  logic [0:0]        rsp_id;
  logic [DW-1:0]     rsp_result;
`ifdef ALU_ARBITER_PERF_EN
  logic [32*NREQ-1:0] grant_cnt;
`endif

  assign req_op   = {op[1], op[0]};
  assign req_src1 = {s1[1], s1[0]};
  assign req_src2 = {s2[1], s2[0]};

  alu_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
`ifdef ALU_ARBITER_PERF_EN
    .grant_cnt  (grant_cnt),
`endif
    .rsp_zero   (rsp_zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: one result slot, a round-robin pointer, grant counts.
  bit          m_valid;
  logic [31:0] m_result;
  int          m_id, m_last;
  int unsigned m_cnt [NREQ];

  task automatic model_reset();
    m_valid = 0; m_result = 0; m_id = 0; m_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a - b;
      3'd4: return (a < b) ? 32'd1 : 32'd0;
      3'd5: return a ^ b;
      3'd6: return (b >= 32) ? 32'd0 : (a << b);
      default: return (b >= 32) ? 32'd0 : (a >> b);
    endcase
  endfunction

  // One clock: check req_ready at negedge, advance model at posedge, check response just after.
  task automatic cycle();
    int g;
    logic [NREQ-1:0] exp_ready;
    @(negedge clk);
    g = -1;
    if (!m_valid || rsp_ready) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check_val("req_ready", req_ready, exp_ready);
    @(posedge clk);
    if (g >= 0) begin
      m_result = ref_alu(op[g], s1[g], s2[g]);
      m_id = g; m_last = g; m_valid = 1;
      m_cnt[g]++;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    #1;
    check_val("rsp_valid", rsp_valid, m_valid);
    check_val("rsp_result", rsp_result, m_result);
    check_val("rsp_id", rsp_id, m_id);
    check_val("rsp_zero", rsp_zero, (m_result == 0));
  endtask

  task automatic set_req(input int i, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op[i] = o; s1[i] = a; s2[i] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ids [4];
    rst_n = 1'b0; rsp_ready = 1'b0; req_valid = 2'b11;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'd2, 32'd1, 32'd1);
    model_reset();
    #12;
    check_val("rst_req_ready", req_ready, 2'b00);
    check_val("rst_rsp_valid", rsp_valid, 1'b0);
    check_val("rst_result", rsp_result, 32'd0);
    check_val("rst_id", rsp_id, 1'b0);
    check_val("rst_zero", rsp_zero, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 2'b00;

    // first transaction: 5 + 7
    req_valid = 2'b01; set_req(0, 3'd2, 32'd5, 32'd7);
    cycle();
    check_val("add_valid", rsp_valid, 1'b1);
    check_val("add_result", rsp_result, 32'd12);
    check_val("add_id", rsp_id, 1'b0);
    check_val("add_zero", rsp_zero, 1'b0);

    // backpressure: outputs frozen, no accepts
    req_valid = 2'b11; set_req(0, 3'd5, 32'hAA, 32'h55); set_req(1, 3'd2, 32'd100, 32'd1);
    for (int n = 0; n < 5; n++) begin
      cycle();
      check_val("hold_result", rsp_result, 32'd12);
      check_val("hold_id", rsp_id, 1'b0);
    end
    rsp_ready = 1'b1; req_valid = 2'b10;
    cycle();
    check_val("reload_result", rsp_result, 32'd101);
    check_val("reload_id", rsp_id, 1'b1);

    // alternation with both requesting
    req_valid = 2'b11;
    exp_ids = '{0, 1, 0, 1};
    for (int n = 0; n < 4; n++) begin
      cycle();
      check_val("rr_id", rsp_id, exp_ids[n]);
      check_val("rr_valid", rsp_valid, 1'b1);
    end

    // boundary ops
    req_valid = 2'b01;
    set_req(0, 3'd3, 32'd3, 32'd3); cycle();
    check_val("sub_zero_res", rsp_result, 32'd0);
    check_val("sub_zero_flag", rsp_zero, 1'b1);
    set_req(0, 3'd6, 32'd1, 32'd32); cycle();
    check_val("sll32", rsp_result, 32'd0);
    set_req(0, 3'd4, 32'hFFFF_FFFF, 32'd1); cycle();
    check_val("slt_unsigned", rsp_result, 32'd0);
    set_req(0, 3'd7, 32'h8000_0000, 32'd31); cycle();
    check_val("srl31", rsp_result, 32'd1);

    // asynchronous reset while FULL
    rsp_ready = 1'b0; set_req(0, 3'd1, 32'hF0, 32'h0F); cycle();
    check_val("full_before_rst", rsp_valid, 1'b1);
    #1; rst_n = 1'b0; #1;
    check_val("async_rsp_valid", rsp_valid, 1'b0);
    check_val("async_req_ready", req_ready, 2'b00);
    check_val("async_zero", rsp_zero, 1'b1);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    cycle(); cycle();
    check_val("no_stale", rsp_valid, 1'b0);

    // 3 transfers for req0, 2 for req1
    req_valid = 2'b01;
    for (int n = 0; n < 3; n++) cycle();
    req_valid = 2'b10;
    for (int n = 0; n < 2; n++) cycle();
    req_valid = 2'b00;
    cycle();
`ifdef ALU_ARBITER_PERF_EN
    check_val("grant_cnt", grant_cnt, {32'd2, 32'd3});
`endif

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        op[i] = 3'($urandom);
        s1[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
        s2[i] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      end
      cycle();
    end
`ifdef ALU_ARBITER_PERF_EN
    check_val("rand_cnt0", grant_cnt[31:0], m_cnt[0]);
    check_val("rand_cnt1", grant_cnt[63:32], m_cnt[1]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
